// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan decoder: parity check, E0/F0 prefix folding into {ext,brk,code}
// events, and a small first-word-fall-through event FIFO.
module ps2_scan_decoder #(
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rx_parity,
  input  logic       rd_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       parity_err,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  state_t           r_st, w_st_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_par_ok, w_drop, w_push_req, w_push, w_pop;
  evt_t             w_evt;

  evt_t             r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr, r_rd, w_wr_nxt, w_rd_nxt;
  logic             r_empty, r_full, r_perr, r_ovf;

  assign w_par_ok = ^{rx_data, rx_parity};
  assign w_drop   = rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_st  <= S_IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Dropped codes fall through to the timeout branch so they neither reset
  // the prefix timer nor change state.
  always_comb begin
    w_st_nxt   = r_st;
    w_cnt_nxt  = r_cnt;
    w_push_req = 1'b0;
    w_evt.ext  = (r_st == S_EXT) || (r_st == S_EXTBRK);
    w_evt.brk  = (r_st == S_BRK) || (r_st == S_EXTBRK);
    w_evt.code = rx_data;
    if (rx_done_tick && !w_par_ok) begin
      w_st_nxt  = S_IDLE;
      w_cnt_nxt = '0;
    end else if (rx_done_tick && !w_drop) begin
      w_cnt_nxt = '0;
      case (r_st)
        S_IDLE: begin
          if (rx_data == 8'hE0)      w_st_nxt = S_EXT;
          else if (rx_data == 8'hF0) w_st_nxt = S_BRK;
          else                       w_push_req = 1'b1;
        end
        S_EXT: begin
          if (rx_data == 8'hF0)      w_st_nxt = S_EXTBRK;
          else if (rx_data != 8'hE0) begin
            w_push_req = 1'b1;
            w_st_nxt   = S_IDLE;
          end
        end
        S_BRK: begin
          if (rx_data == 8'hE0)      w_st_nxt = S_EXTBRK;
          else if (rx_data != 8'hF0) begin
            w_push_req = 1'b1;
            w_st_nxt   = S_IDLE;
          end
        end
        default: begin
          if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
            w_push_req = 1'b1;
            w_st_nxt   = S_IDLE;
          end
        end
      endcase
    end else if (r_st != S_IDLE) begin
      if (r_cnt == TO_LAST) begin
        w_st_nxt  = S_IDLE;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // FIFO: a pop frees the slot in the same edge, so push-while-full is legal with rd_en.
  assign w_pop    = rd_en && !r_empty;
  assign w_push   = w_push_req && (!r_full || w_pop);
  assign w_wr_nxt = r_wr + {{FIFO_AW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd + {{FIFO_AW{1'b0}}, w_pop};

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr[FIFO_AW-1:0]] <= w_evt;
    end
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_perr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_empty <= (w_wr_nxt == w_rd_nxt);
      r_full  <= (w_wr_nxt[FIFO_AW] != w_rd_nxt[FIFO_AW]) &&
                 (w_wr_nxt[FIFO_AW-1:0] == w_rd_nxt[FIFO_AW-1:0]);
      r_perr  <= rx_done_tick && !w_par_ok;
      r_ovf   <= w_push_req && r_full && !w_pop;
    end
  end

  assign {key_ext, key_brk, key_code} = r_mem[r_rd[FIFO_AW-1:0]];
  assign fifo_empty = r_empty;
  assign fifo_full  = r_full;
  assign parity_err = r_perr;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder with a short prefix timeout.
module tb_ps2_scan_decoder;
  logic       reloj = 1'b0, reset = 1'b1;
  logic       rx_done_tick = 1'b0, rx_parity = 1'b0, rd_en = 1'b0;
  logic [7:0] rx_data = '0;
  logic [7:0] key_code;
  logic       key_ext, key_brk, fifo_empty, fifo_full, parity_err, overflow;
  int         n_pass = 0, n_tot = 0;

  ps2_scan_decoder #(.FIFO_AW(2), .TIMEOUT_CYC(100), .CNT_W(20)) dut (
    .reloj(reloj), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_parity(rx_parity), .rd_en(rd_en), .key_code(key_code), .key_ext(key_ext),
    .key_brk(key_brk), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .parity_err(parity_err), .overflow(overflow)
  );

  always #5 reloj = ~reloj;

  wire [9:0] w_key = {key_ext, key_brk, key_code};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] ev(input logic e, input logic b, input logic [7:0] c);
    return {6'b0, e, b, c};
  endfunction

  // Called at a negedge; the tick is sampled by the next posedge, returns at the following negedge.
  task automatic send(input logic [7:0] d, input logic bad = 1'b0, input logic pop = 1'b0);
    rx_data = d; rx_parity = ~^d ^ bad; rx_done_tick = 1'b1; rd_en = pop;
    @(negedge reloj);
    rx_done_tick = 1'b0; rd_en = 1'b0;
  endtask

  task automatic pop1;
    rd_en = 1'b1;
    @(negedge reloj);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge reloj);
    chk("rst_empty", 16'(fifo_empty), 16'd1);
    chk("rst_flags", {13'b0, fifo_full, parity_err, overflow}, 16'd0);
    chk("rst_key", 16'(w_key), 16'd0);
    reset = 1'b0;
    @(negedge reloj);

    // 1: plain make code
    send(8'h1C);
    chk("t1_empty", 16'(fifo_empty), 16'd0);
    chk("t1_key", 16'(w_key), ev(0, 0, 8'h1C));
    pop1;
    chk("t1_pop_empty", 16'(fifo_empty), 16'd1);

    // 2: prefixed events
    send(8'hE0);
    chk("t2_e0_noevt", 16'(fifo_empty), 16'd1);
    send(8'hF0);
    chk("t2_f0_noevt", 16'(fifo_empty), 16'd1);
    send(8'h75);
    chk("t2_extbrk", 16'(w_key), ev(1, 1, 8'h75));
    pop1;
    chk("t2_single", 16'(fifo_empty), 16'd1);
    send(8'hF0);
    send(8'h1C);
    chk("t2_brk", 16'(w_key), ev(0, 1, 8'h1C));
    pop1;

    // 3: parity errors
    send(8'h1C, 1'b1);
    chk("t3_perr_pulse", 16'(parity_err), 16'd1);
    chk("t3_perr_empty", 16'(fifo_empty), 16'd1);
    @(negedge reloj);
    chk("t3_perr_clear", 16'(parity_err), 16'd0);
    send(8'hE0);
    send(8'h75, 1'b1);
    send(8'h75);
    chk("t3_prefix_lost", 16'(w_key), ev(0, 0, 8'h75));
    pop1;
    chk("t3_single", 16'(fifo_empty), 16'd1);

    // 4: prefix timeout (TIMEOUT_CYC = 100)
    send(8'hF0);
    repeat (100) @(negedge reloj);
    send(8'h1C);
    chk("t4_timed_out", 16'(w_key), ev(0, 0, 8'h1C));
    pop1;
    send(8'hF0);
    repeat (98) @(negedge reloj);
    send(8'h1C);
    chk("t4_in_time", 16'(w_key), ev(0, 1, 8'h1C));
    pop1;

    // 5: fill, overflow, ordered drain, push+pop while full
    for (int i = 0; i < 4; i++) begin
      send(8'h15 + 8'(i));
      chk($sformatf("t5_full_%0d", i), 16'(fifo_full), 16'(i == 3));
    end
    send(8'h19);
    chk("t5_ovf_pulse", 16'(overflow), 16'd1);
    @(negedge reloj);
    chk("t5_ovf_clear", 16'(overflow), 16'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_rd_%0d", i), 16'(w_key), ev(0, 0, 8'h15 + 8'(i)));
      pop1;
    end
    chk("t5_drained", 16'(fifo_empty), 16'd1);
    for (int i = 0; i < 4; i++) send(8'h21 + 8'(i));
    send(8'h25, 1'b0, 1'b1);
    chk("t5_pp_noovf", 16'(overflow), 16'd0);
    chk("t5_pp_full", 16'(fifo_full), 16'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_pp_rd_%0d", i), 16'(w_key), ev(0, 0, 8'h22 + 8'(i)));
      pop1;
    end
    chk("t5_pp_drained", 16'(fifo_empty), 16'd1);

    // push+pop with one entry: head replaced, never empty
    send(8'h1C);
    send(8'h2A, 1'b0, 1'b1);
    chk("t5_one_empty", 16'(fifo_empty), 16'd0);
    chk("t5_one_head", 16'(w_key), ev(0, 0, 8'h2A));
    pop1;

    // 6: dropped codes, then reset mid-sequence
    send(8'hFA);
    send(8'hAA);
    chk("t6_drop_idle", 16'(fifo_empty), 16'd1);
    send(8'hF0);
    send(8'hFA);
    send(8'h1C);
    chk("t6_drop_brk", 16'(w_key), ev(0, 1, 8'h1C));
    pop1;
    chk("t6_single", 16'(fifo_empty), 16'd1);
    send(8'h11);
    send(8'h12);
    send(8'hE0);
    chk("t6_queued", 16'(w_key), ev(0, 0, 8'h11));
    reset = 1'b1;
    #1;
    chk("t6_rst_empty", 16'(fifo_empty), 16'd1);
    @(negedge reloj);
    reset = 1'b0;
    @(negedge reloj);
    send(8'h1C);
    chk("t6_post_rst", 16'(w_key), ev(0, 0, 8'h1C));
    pop1;
    chk("t6_post_single", 16'(fifo_empty), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
